// File: rtl/jacobi_pair_scheduler.sv
// Circle-method (p,q) pair scheduler that feeds the vectoring CORDIC during CALC_ANGLES.
// Optional macro JACOBI_SCHED_THRESH_EN adds thresh_i to force identity rotations for small a_pq.
module jacobi_pair_scheduler #(
    parameter int N              = 8,
    parameter int OUT_WORD_WIDTH = 20,
    parameter int MEM_ADDR_WIDTH = 7,
    parameter int IDX_WIDTH      = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [7:0]                sweeps_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      round_done_o,
    input  logic                      round_ack_i,
    output logic                      ram_en_a_o,
    output logic [MEM_ADDR_WIDTH-1:0] ram_addr_a_o,
    input  logic [OUT_WORD_WIDTH-1:0] ram_dout_a_i,
    output logic                      ram_en_b_o,
    output logic [MEM_ADDR_WIDTH-1:0] ram_addr_b_o,
    input  logic [OUT_WORD_WIDTH-1:0] ram_dout_b_i,
    output logic [OUT_WORD_WIDTH-1:0] vectoring_in_dat_x_o,
    output logic [OUT_WORD_WIDTH-1:0] vectoring_in_dat_y_o,
    output logic [OUT_WORD_WIDTH-1:0] vectoring_in_dat_z_o,
    output logic                      vectoring_in_vld_o,
    output logic [IDX_WIDTH-1:0]      pair_p_o,
    output logic [IDX_WIDTH-1:0]      pair_q_o,
    output logic [IDX_WIDTH-1:0]      round_o
`ifdef JACOBI_SCHED_THRESH_EN
    ,
    input  logic [OUT_WORD_WIDTH-1:0] thresh_i
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RD_DIAG,
        RD_OFF,
        EMIT,
        WAIT_ACK,
        DONE
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_PAIR  = IDX_WIDTH'(N / 2 - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_ROUND = IDX_WIDTH'(N - 2);

    // Tournament seating: position 0 is fixed, the rest rotate by one seat per round.
    function automatic int posOf(input int pos, input int rnd);
        int s;
        if (pos == 0) return 0;
        s = pos - 1 + rnd;
        if (s >= N - 1) s = s - (N - 1);
        return s + 1;
    endfunction

    function automatic logic [2*IDX_WIDTH-1:0] pairOf(input logic [IDX_WIDTH-1:0] rnd,
                                                      input logic [IDX_WIDTH-1:0] k);
        int a;
        int b;
        a = posOf(int'(k), int'(rnd));
        b = posOf(N - 1 - int'(k), int'(rnd));
        if (a < b) return {IDX_WIDTH'(a), IDX_WIDTH'(b)};
        return {IDX_WIDTH'(b), IDX_WIDTH'(a)};
    endfunction

    function automatic logic [MEM_ADDR_WIDTH-1:0] addrOf(input logic [IDX_WIDTH-1:0] r,
                                                         input logic [IDX_WIDTH-1:0] c);
        return MEM_ADDR_WIDTH'(int'(r) * N + int'(c));
    endfunction

    state_t                    r_state;
    logic [IDX_WIDTH-1:0]      r_round;
    logic [IDX_WIDTH-1:0]      r_pair;
    logic [IDX_WIDTH-1:0]      r_p;
    logic [IDX_WIDTH-1:0]      r_q;
    logic [7:0]                r_sweep;
    logic [7:0]                r_sweeps;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_roundDone;
    logic                      r_enA;
    logic                      r_enB;
    logic [MEM_ADDR_WIDTH-1:0] r_addrA;
    logic [MEM_ADDR_WIDTH-1:0] r_addrB;
    logic                      r_vld;
    logic [OUT_WORD_WIDTH-1:0] r_x;

    logic [IDX_WIDTH-1:0]      w_pairNext;
    logic [IDX_WIDTH-1:0]      w_roundNext;
    logic [7:0]                w_sweepNext;
    logic [2*IDX_WIDTH-1:0]    w_loadPair;
    logic [IDX_WIDTH-1:0]      w_loadP;
    logic [IDX_WIDTH-1:0]      w_loadQ;

    assign w_pairNext  = r_pair + IDX_WIDTH'(1);
    assign w_roundNext = r_round + IDX_WIDTH'(1);
    assign w_sweepNext = r_sweep + 8'd1;

    // Indices of the pair about to be read, for whichever transition enters RD_DIAG.
    always_comb begin
        w_loadPair = pairOf('0, '0);
        case (r_state)
            EMIT:     w_loadPair = pairOf(r_round, w_pairNext);
            WAIT_ACK: if (r_round != LAST_ROUND) w_loadPair = pairOf(w_roundNext, '0);
            default:  ;
        endcase
    end

    assign w_loadP = w_loadPair[2*IDX_WIDTH-1:IDX_WIDTH];
    assign w_loadQ = w_loadPair[IDX_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_round     <= '0;
            r_pair      <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_sweep     <= '0;
            r_sweeps    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_roundDone <= 1'b0;
            r_enA       <= 1'b0;
            r_enB       <= 1'b0;
            r_addrA     <= '0;
            r_addrB     <= '0;
            r_vld       <= 1'b0;
            r_x         <= '0;
        end else begin
            r_enA       <= 1'b0;
            r_enB       <= 1'b0;
            r_vld       <= 1'b0;
            r_roundDone <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_sweeps <= sweeps_i;
                        r_sweep  <= '0;
                        r_round  <= '0;
                        r_pair   <= '0;
                        r_busy   <= 1'b1;
                        if (sweeps_i != 8'd0) begin
                            r_state <= RD_DIAG;
                            r_p     <= w_loadP;
                            r_q     <= w_loadQ;
                            r_enA   <= 1'b1;
                            r_enB   <= 1'b1;
                            r_addrA <= addrOf(w_loadP, w_loadP);
                            r_addrB <= addrOf(w_loadQ, w_loadQ);
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                RD_DIAG: begin
                    r_state <= RD_OFF;
                    r_enA   <= 1'b1;
                    r_addrA <= addrOf(r_p, r_q);
                end
                RD_OFF: begin
                    r_state <= EMIT;
                    r_vld   <= 1'b1;
                    r_x     <= ram_dout_b_i - ram_dout_a_i;
                end
                EMIT: begin
                    if (r_pair == LAST_PAIR) begin
                        r_state     <= WAIT_ACK;
                        r_roundDone <= 1'b1;
                    end else begin
                        r_state <= RD_DIAG;
                        r_pair  <= w_pairNext;
                        r_p     <= w_loadP;
                        r_q     <= w_loadQ;
                        r_enA   <= 1'b1;
                        r_enB   <= 1'b1;
                        r_addrA <= addrOf(w_loadP, w_loadP);
                        r_addrB <= addrOf(w_loadQ, w_loadQ);
                    end
                end
                WAIT_ACK: begin
                    if (round_ack_i) begin
                        r_pair <= '0;
                        if (r_round != LAST_ROUND) begin
                            r_round <= w_roundNext;
                        end else begin
                            r_round <= '0;
                            r_sweep <= w_sweepNext;
                        end
                        if (r_round == LAST_ROUND && w_sweepNext == r_sweeps) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= RD_DIAG;
                            r_p     <= w_loadP;
                            r_q     <= w_loadQ;
                            r_enA   <= 1'b1;
                            r_enB   <= 1'b1;
                            r_addrA <= addrOf(w_loadP, w_loadP);
                            r_addrB <= addrOf(w_loadQ, w_loadQ);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // a_pq arrives from port A during EMIT itself, so y is taken straight from the read data.
`ifdef JACOBI_SCHED_THRESH_EN
    logic [OUT_WORD_WIDTH-1:0] w_absPq;
    logic                      w_small;

    assign w_absPq = ram_dout_a_i[OUT_WORD_WIDTH-1] ? (~ram_dout_a_i + OUT_WORD_WIDTH'(1))
                                                    : ram_dout_a_i;
    assign w_small = (w_absPq <= thresh_i);

    assign vectoring_in_dat_x_o = (r_vld && w_small) ? OUT_WORD_WIDTH'(1) : r_x;
    assign vectoring_in_dat_y_o = (r_vld && !w_small) ? (ram_dout_a_i << 1) : '0;
`else
    assign vectoring_in_dat_x_o = r_x;
    assign vectoring_in_dat_y_o = r_vld ? (ram_dout_a_i << 1) : '0;
`endif

    assign vectoring_in_dat_z_o = '0;
    assign vectoring_in_vld_o   = r_vld;
    assign busy_o               = r_busy;
    assign done_o               = r_done;
    assign round_done_o         = r_roundDone;
    assign ram_en_a_o           = r_enA;
    assign ram_en_b_o           = r_enB;
    assign ram_addr_a_o         = r_addrA;
    assign ram_addr_b_o         = r_addrB;
    assign pair_p_o             = r_p;
    assign pair_q_o             = r_q;
    assign round_o              = r_round;

endmodule

// File: tb/tb_jacobi_pair_scheduler.sv
// Scoreboard bench for jacobi_pair_scheduler at N=4 with a 1-cycle-latency RAM model.
// Threshold scenario is compiled in only with JACOBI_SCHED_THRESH_EN.
module tb_jacobi_pair_scheduler;

    localparam int N  = 4;
    localparam int W  = 20;
    localparam int AW = 4;
    localparam int IW = 2;

    // Expected round-robin order for N=4: round r holds entries 2r and 2r+1.
    localparam int TP [6] = '{0, 1, 0, 2, 0, 1};
    localparam int TQ [6] = '{3, 2, 1, 3, 2, 3};

    typedef struct packed {
        logic [IW-1:0] p;
        logic [IW-1:0] q;
        logic [IW-1:0] rnd;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
    } emit_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    sweeps;
    logic          busy;
    logic          done;
    logic          roundDone;
    logic          ack;
    logic          enA;
    logic [AW-1:0] addrA;
    logic [W-1:0]  doutA = '0;
    logic          enB;
    logic [AW-1:0] addrB;
    logic [W-1:0]  doutB = '0;
    logic [W-1:0]  datX;
    logic [W-1:0]  datY;
    logic [W-1:0]  datZ;
    logic          vld;
    logic [IW-1:0] pairP;
    logic [IW-1:0] pairQ;
    logic [IW-1:0] roundIdx;
`ifdef JACOBI_SCHED_THRESH_EN
    logic [W-1:0]  thresh;
`endif

    logic [W-1:0]  mem [16];
    emit_t         expQ[$];

    int checks = 0;
    int errors = 0;
    int vldCount = 0;
    int doneCount = 0;
    int roundDoneCount = 0;
    int roundsAcked = 0;
    int enCount = 0;

    jacobi_pair_scheduler #(
        .N(N),
        .OUT_WORD_WIDTH(W),
        .MEM_ADDR_WIDTH(AW),
        .IDX_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start),
        .sweeps_i(sweeps),
        .busy_o(busy),
        .done_o(done),
        .round_done_o(roundDone),
        .round_ack_i(ack),
        .ram_en_a_o(enA),
        .ram_addr_a_o(addrA),
        .ram_dout_a_i(doutA),
        .ram_en_b_o(enB),
        .ram_addr_b_o(addrB),
        .ram_dout_b_i(doutB),
        .vectoring_in_dat_x_o(datX),
        .vectoring_in_dat_y_o(datY),
        .vectoring_in_dat_z_o(datZ),
        .vectoring_in_vld_o(vld),
        .pair_p_o(pairP),
        .pair_q_o(pairQ),
        .round_o(roundIdx)
`ifdef JACOBI_SCHED_THRESH_EN
        ,
        .thresh_i(thresh)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (enA) doutA <= mem[addrA];
        if (enB) doutB <= mem[addrB];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic pushExpected(input int sw, input int thr, input bit thrEn);
        emit_t        e;
        logic [W-1:0] apq;
        logic [W-1:0] mag;
        int           p;
        int           q;
        for (int s = 0; s < sw; s++) begin
            for (int i = 0; i < 6; i++) begin
                p     = TP[i];
                q     = TQ[i];
                apq   = mem[p * N + q];
                mag   = ($signed(apq) < 0) ? W'(-$signed(apq)) : apq;
                e.p   = IW'(p);
                e.q   = IW'(q);
                e.rnd = IW'(i / 2);
                if (thrEn && mag <= W'(thr)) begin
                    e.x = W'(1);
                    e.y = '0;
                end else begin
                    e.x = mem[q * N + q] - mem[p * N + p];
                    e.y = apq << 1;
                end
                expQ.push_back(e);
            end
        end
    endtask

    // One clock step; samples #1 after the edge and scores any emitted pair.
    task automatic tick();
        emit_t e;
        @(posedge clk);
        #1;
        if (enA || enB) enCount++;
        if (roundDone) roundDoneCount++;
        if (done) doneCount++;
        if (vld) begin
            vldCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_vld", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("pair_p", 32'(pairP), 32'(e.p));
                checkOutput("pair_q", 32'(pairQ), 32'(e.q));
                checkOutput("round", 32'(roundIdx), 32'(e.rnd));
                checkOutput("dat_x", 32'(datX), 32'(e.x));
                checkOutput("dat_y", 32'(datY), 32'(e.y));
                checkOutput("dat_z", 32'(datZ), 32'd0);
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] sw);
        start  = 1'b1;
        sweeps = sw;
        tick();
        start  = 1'b0;
    endtask

    task automatic waitRoundDone();
        int n = 0;
        while (roundDoneCount <= roundsAcked && n < 200) begin
            tick();
            n++;
        end
        checkOutput("round_done_seen", 32'(roundDoneCount > roundsAcked), 32'd1);
    endtask

    task automatic ackRound(input int gap);
        waitRoundDone();
        repeat (gap) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        roundsAcked++;
    endtask

    task automatic waitDone(input int base);
        int n = 0;
        while (doneCount == base && n < 100) begin
            tick();
            n++;
        end
        checkOutput("done_seen", 32'(doneCount), 32'(base + 1));
    endtask

    initial begin
        int vldBase;
        int doneBase;
        int enBase;
        int busyLow;

        rst    = 1'b1;
        start  = 1'b0;
        sweeps = 8'd0;
        ack    = 1'b0;
`ifdef JACOBI_SCHED_THRESH_EN
        thresh = '0;
`endif
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mem[r * N + c] = W'(10 * r + c);

        $display("[TB] reset");
        repeat (3) tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ctrl", {26'd0, done, roundDone, enA, enB, vld, 1'b0}, 32'd0);
        checkOutput("rst_addr", {24'd0, addrA, addrB}, 32'd0);
        checkOutput("rst_xy", 32'(datX | datY | datZ), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] single sweep");
        vldBase  = vldCount;
        doneBase = doneCount;
        pushExpected(1, 0, 1'b0);
        applyStimulus(8'd1);
        checkOutput("diag_en_a", 32'(enA), 32'd1);
        checkOutput("diag_en_b", 32'(enB), 32'd1);
        checkOutput("diag_addr_a", 32'(addrA), 32'd0);
        checkOutput("diag_addr_b", 32'(addrB), 32'd15);
        checkOutput("busy_running", 32'(busy), 32'd1);
        tick();
        checkOutput("off_en_a", 32'(enA), 32'd1);
        checkOutput("off_en_b", 32'(enB), 32'd0);
        checkOutput("off_addr_a", 32'(addrA), 32'd3);
        tick();
        checkOutput("first_vld_latency", 32'(vldCount), 32'(vldBase + 1));
        repeat (3) ackRound(2);
        waitDone(doneBase);
        checkOutput("sweep1_vld_total", 32'(vldCount), 32'(vldBase + 6));
        checkOutput("sweep1_queue_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] two sweeps");
        vldBase  = vldCount;
        doneBase = doneCount;
        pushExpected(2, 0, 1'b0);
        applyStimulus(8'd2);
        repeat (5) ackRound(2);
        checkOutput("no_early_done", 32'(doneCount), 32'(doneBase));
        ackRound(2);
        waitDone(doneBase);
        repeat (5) tick();
        checkOutput("sweep2_single_done", 32'(doneCount), 32'(doneBase + 1));
        checkOutput("sweep2_vld_total", 32'(vldCount), 32'(vldBase + 12));
        checkOutput("sweep2_queue_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] withheld ack and start while busy");
        doneBase = doneCount;
        pushExpected(1, 0, 1'b0);
        applyStimulus(8'd1);
        waitRoundDone();
        enBase  = enCount;
        vldBase = vldCount;
        busyLow = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                start  = 1'b1;
                sweeps = 8'd0;
            end
            tick();
            start = 1'b0;
            if (!busy) busyLow++;
        end
        checkOutput("wait_no_ram", 32'(enCount), 32'(enBase));
        checkOutput("wait_no_vld", 32'(vldCount), 32'(vldBase));
        checkOutput("wait_busy", 32'(busyLow), 32'd0);
        checkOutput("busy_start_ignored", 32'(doneCount), 32'(doneBase));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        roundsAcked++;
        repeat (2) ackRound(2);
        waitDone(doneBase);
        checkOutput("wait_queue_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] zero sweeps");
        doneBase = doneCount;
        vldBase  = vldCount;
        applyStimulus(8'd0);
        checkOutput("zero_done_not_yet", 32'(done), 32'd0);
        checkOutput("zero_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("zero_done_pulse", 32'(done), 32'd1);
        checkOutput("zero_idle", 32'(busy), 32'd0);
        tick();
        checkOutput("zero_no_vld", 32'(vldCount), 32'(vldBase));
        checkOutput("zero_done_count", 32'(doneCount), 32'(doneBase + 1));

        $display("[TB] reset mid-sweep");
        vldBase = vldCount;
        pushExpected(1, 0, 1'b0);
        applyStimulus(8'd1);
        for (int n = 0; n < 50 && vldCount < vldBase + 2; n++) tick();
        checkOutput("abort_two_vld", 32'(vldCount), 32'(vldBase + 2));
        tick();
        rst = 1'b1;
        tick();
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ctrl", {26'd0, done, roundDone, enA, enB, vld, 1'b0}, 32'd0);
        checkOutput("abort_addr", {24'd0, addrA, addrB}, 32'd0);
        checkOutput("abort_xy", 32'(datX | datY | datZ), 32'd0);
        checkOutput("abort_idx", {26'd0, pairP, pairQ, roundIdx}, 32'd0);
        rst = 1'b0;
        expQ.delete();
        roundsAcked = roundDoneCount;
        doneBase    = doneCount;
        repeat (3) tick();
        checkOutput("abort_no_done", 32'(doneCount), 32'(doneBase));
        pushExpected(1, 0, 1'b0);
        applyStimulus(8'd1);
        repeat (3) ackRound(2);
        waitDone(doneBase);
        checkOutput("restart_queue_empty", 32'(expQ.size()), 32'd0);

`ifdef JACOBI_SCHED_THRESH_EN
        $display("[TB] threshold");
        mem[3]   = W'(5);
        thresh   = W'(5);
        doneBase = doneCount;
        pushExpected(1, 5, 1'b1);
        applyStimulus(8'd1);
        repeat (3) ackRound(2);
        waitDone(doneBase);
        thresh   = W'(4);
        doneBase = doneCount;
        pushExpected(1, 4, 1'b1);
        applyStimulus(8'd1);
        repeat (3) ackRound(2);
        waitDone(doneBase);
        checkOutput("thresh_queue_empty", 32'(expQ.size()), 32'd0);
        mem[3] = W'(3);
        thresh = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
